// File: rtl/fp_norm_pkg.sv
// Shared widths, format constants and lane record types for the FP operand normalizer.
package fp_norm_pkg;

  localparam int unsigned FLEN   = 64;
  localparam int unsigned EXP_W  = 13;
  localparam int unsigned MANT_W = 53;
  localparam int unsigned LZC_W  = $clog2(MANT_W + 1);

  localparam int unsigned SP_EXP_BITS  = 8;
  localparam int unsigned SP_FRAC_BITS = 23;
  localparam int unsigned SP_BIAS      = 127;
  localparam int unsigned DP_EXP_BITS  = 11;
  localparam int unsigned DP_FRAC_BITS = 52;
  localparam int unsigned DP_BIAS      = 1023;

  localparam logic [31:0] SP_CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic is_zero;
    logic is_subnormal;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp_norm_class_t;

  // Stage 1 record: raw fields plus the shift amount needed by stage 2.
  typedef struct packed {
    logic                    sign;
    logic [DP_EXP_BITS-1:0]  exp_field;
    logic [MANT_W-1:0]       mant;
    logic [LZC_W-1:0]        lzc;
    fp_norm_class_t          cls;
    logic                    box_fail;
  } fp_norm_s1_t;

  typedef struct packed {
    logic                    sign;
    logic [EXP_W-1:0]        exp;
    logic [MANT_W-1:0]       mant;
    fp_norm_class_t          cls;
    logic                    box_fail;
  } fp_norm_lane_t;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 53,
  parameter int unsigned CntW  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CntW-1:0]  cnt_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt_o = CntW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = CntW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_operand_normalizer.sv
// Two-stage FP operand unpacker: extract/classify/count in stage 1, normalize in stage 2.
module fp_operand_normalizer
  import fp_norm_pkg::*;
#(
  parameter int unsigned NUM_OPS = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_fmt_double,
  input  logic [NUM_OPS*FLEN-1:0]   i_operands,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_fmt_double,
  output logic [NUM_OPS-1:0]        o_sign,
  output logic [NUM_OPS*EXP_W-1:0]  o_exp,
  output logic [NUM_OPS*MANT_W-1:0] o_mant,
  output logic [NUM_OPS-1:0]        o_is_zero,
  output logic [NUM_OPS-1:0]        o_is_subnormal,
  output logic [NUM_OPS-1:0]        o_is_inf,
  output logic [NUM_OPS-1:0]        o_is_nan,
  output logic [NUM_OPS-1:0]        o_is_snan,
  output logic [NUM_OPS-1:0]        o_box_fail
);

  fp_norm_s1_t   [NUM_OPS-1:0] s1_d, s1_q;
  fp_norm_lane_t [NUM_OPS-1:0] s2_d, s2_q;
  logic s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic s1_fmt_q, s2_fmt_q;
  logic accept, s1_advance;

  assign s1_advance = s1_valid_q & (~s2_valid_q | i_ready);
  assign o_ready    = ~s1_valid_q | s1_advance;
  assign accept     = i_valid & o_ready & ~i_flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (i_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)          s1_valid_d = 1'b1;
      else if (s1_advance) s1_valid_d = 1'b0;
      if (s1_advance)      s2_valid_d = 1'b1;
      else if (i_ready)    s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s1_fmt_q   <= 1'b0;
      s2_fmt_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_q     <= s1_d;
        s1_fmt_q <= i_fmt_double;
      end
      if (s1_advance && !i_flush) begin
        s2_q     <= s2_d;
        s2_fmt_q <= s1_fmt_q;
      end
    end
  end

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_lane
    logic [FLEN-1:0]         op;
    logic [31:0]             sp_word;
    logic                    lane_sign, lane_box, exp_zero, exp_ones, frac_zero;
    logic [DP_EXP_BITS-1:0]  lane_exp;
    logic [DP_FRAC_BITS-1:0] frac;
    logic [MANT_W-1:0]       mant_al;
    logic [LZC_W-1:0]        lzc;
    fp_norm_class_t          lane_cls;
    fp_norm_lane_t           s2_lane;

    assign op = i_operands[k*FLEN +: FLEN];

    // Single lanes are widened so both formats share one left-aligned datapath.
    always_comb begin
      sp_word   = op[31:0];
      lane_box  = 1'b0;
      lane_sign = op[FLEN-1];
      lane_exp  = op[DP_FRAC_BITS +: DP_EXP_BITS];
      frac      = op[DP_FRAC_BITS-1:0];
      exp_ones  = &op[DP_FRAC_BITS +: DP_EXP_BITS];
      if (!i_fmt_double) begin
        lane_box = ~&op[FLEN-1:32];
        if (lane_box) sp_word = SP_CANON_NAN;
        lane_sign = sp_word[31];
        lane_exp  = DP_EXP_BITS'(sp_word[SP_FRAC_BITS +: SP_EXP_BITS]);
        frac      = {sp_word[SP_FRAC_BITS-1:0], {(DP_FRAC_BITS - SP_FRAC_BITS){1'b0}}};
        exp_ones  = &sp_word[SP_FRAC_BITS +: SP_EXP_BITS];
      end
    end

    assign exp_zero  = (lane_exp == '0);
    assign frac_zero = (frac == '0);
    assign mant_al   = {~exp_zero, frac};

    assign lane_cls = '{
      is_zero:      exp_zero & frac_zero,
      is_subnormal: exp_zero & ~frac_zero,
      is_inf:       exp_ones & frac_zero,
      is_nan:       exp_ones & ~frac_zero,
      is_snan:      exp_ones & ~frac_zero & ~frac[DP_FRAC_BITS-1]
    };

    fp_lzc #(
      .WIDTH (MANT_W)
    ) u_lzc (
      .data_i (mant_al),
      .cnt_o  (lzc)
    );

    assign s1_d[k] = '{
      sign:      lane_sign,
      exp_field: lane_exp,
      mant:      mant_al,
      lzc:       lzc,
      cls:       lane_cls,
      box_fail:  lane_box
    };

    // Normal and NaN mantissas already have MSB set, so their lzc is zero.
    always_comb begin
      s2_lane          = '0;
      s2_lane.sign     = s1_q[k].sign;
      s2_lane.cls      = s1_q[k].cls;
      s2_lane.box_fail = s1_q[k].box_fail;
      s2_lane.exp      = s1_q[k].cls.is_subnormal ? EXP_W'(1) - EXP_W'(s1_q[k].lzc)
                                                  : EXP_W'(s1_q[k].exp_field);
      s2_lane.mant     = s1_q[k].cls.is_inf ? '0 : s1_q[k].mant << s1_q[k].lzc;
    end

    assign s2_d[k] = s2_lane;

    assign o_sign[k]                    = s2_q[k].sign;
    assign o_exp[k*EXP_W +: EXP_W]      = s2_q[k].exp;
    assign o_mant[k*MANT_W +: MANT_W]   = s2_q[k].mant;
    assign o_is_zero[k]                 = s2_q[k].cls.is_zero;
    assign o_is_subnormal[k]            = s2_q[k].cls.is_subnormal;
    assign o_is_inf[k]                  = s2_q[k].cls.is_inf;
    assign o_is_nan[k]                  = s2_q[k].cls.is_nan;
    assign o_is_snan[k]                 = s2_q[k].cls.is_snan;
    assign o_box_fail[k]                = s2_q[k].box_fail;
  end

  assign o_valid      = s2_valid_q;
  assign o_fmt_double = s2_fmt_q;

endmodule

// File: tb/tb_fp_operand_normalizer.sv
// Scoreboarded bench for fp_operand_normalizer: directed classes, stalls, flush, reset, random.
`timescale 1ns/1ps
module tb_fp_operand_normalizer;

  localparam int unsigned N  = 3;
  localparam int unsigned EW = 13;
  localparam int unsigned MW = 53;
  localparam logic [MW-1:0] MANT_ONE = 53'h10_0000_0000_0000;

  typedef struct packed {
    logic          fmt;
    logic [N-1:0]  sign;
    logic [N*EW-1:0] exp;
    logic [N*MW-1:0] mant;
    logic [N-1:0]  zero, sub, inf, nan, snan, box;
  } obs_t;

  logic i_clk = 1'b0;
  logic i_rst, i_flush, i_valid, o_ready, i_fmt_double, o_valid, i_ready, o_fmt_double;
  logic [N*64-1:0] i_operands;
  logic [N-1:0]    o_sign, o_is_zero, o_is_subnormal, o_is_inf, o_is_nan, o_is_snan, o_box_fail;
  logic [N*EW-1:0] o_exp;
  logic [N*MW-1:0] o_mant;

  obs_t obs, exp_o, snap;
  obs_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  fp_operand_normalizer #(
    .NUM_OPS (N)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_flush        (i_flush),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_fmt_double   (i_fmt_double),
    .i_operands     (i_operands),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_fmt_double   (o_fmt_double),
    .o_sign         (o_sign),
    .o_exp          (o_exp),
    .o_mant         (o_mant),
    .o_is_zero      (o_is_zero),
    .o_is_subnormal (o_is_subnormal),
    .o_is_inf       (o_is_inf),
    .o_is_nan       (o_is_nan),
    .o_is_snan      (o_is_snan),
    .o_box_fail     (o_box_fail)
  );

  assign obs = {o_fmt_double, o_sign, o_exp, o_mant, o_is_zero, o_is_subnormal, o_is_inf,
                o_is_nan, o_is_snan, o_box_fail};

  // Reference: generic field split, then normalize subnormals one bit at a time.
  function automatic obs_t model(input logic dbl, input logic [N*64-1:0] ops);
    obs_t r;
    r = '0;
    r.fmt = dbl;
    for (int k = 0; k < N; k++) begin
      logic [63:0] v, e, f, emax;
      logic [MW-1:0] m;
      int eb, fb, ex;
      v  = ops[k*64 +: 64];
      eb = dbl ? 11 : 8;
      fb = dbl ? 52 : 23;
      if (!dbl) begin
        if (v[63:32] !== 32'hFFFF_FFFF) begin
          r.box[k] = 1'b1;
          v = 64'h0000_0000_7FC0_0000;
        end else begin
          v = {32'd0, v[31:0]};
        end
      end
      r.sign[k] = v[eb + fb];
      emax = (64'd1 << eb) - 64'd1;
      e    = (v >> fb) & emax;
      f    = v & ((64'd1 << fb) - 64'd1);
      m    = MW'(f << (52 - fb));
      ex   = int'(e);
      if (e == emax) begin
        if (f == 64'd0) begin
          r.inf[k] = 1'b1;
          m = '0;
        end else begin
          r.nan[k]  = 1'b1;
          r.snan[k] = ~f[fb-1];
          m[MW-1]   = 1'b1;
        end
      end else if (e == 64'd0) begin
        if (f == 64'd0) begin
          r.zero[k] = 1'b1;
        end else begin
          r.sub[k] = 1'b1;
          ex = 1;
          while (!m[MW-1]) begin
            m = m << 1;
            ex--;
          end
        end
      end else begin
        m[MW-1] = 1'b1;
      end
      r.exp[k*EW +: EW]  = EW'(ex);
      r.mant[k*MW +: MW] = m;
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_op(input logic dbl);
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: r = dbl ? (r & 64'h800F_FFFF_FFFF_FFFF) : (r & 64'h0000_0000_807F_FFFF);
      1: r = dbl ? (r | 64'h7FF0_0000_0000_0000) : (r | 64'h0000_0000_7F80_0000);
      2: r = dbl ? (r & 64'h8000_0000_0000_00FF) : (r & 64'h0000_0000_8000_00FF);
      default: ;
    endcase
    if (!dbl) r[63:32] = ($urandom_range(0, 7) == 0) ? $urandom : 32'hFFFF_FFFF;
    return r;
  endfunction

  // Inputs are already settled; record an accept, then advance one cycle.
  task automatic tick();
    if (i_valid && o_ready && !i_flush && !i_rst) sb.push_back(model(i_fmt_double, i_operands));
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_fmt_double = 1'b0; i_operands = '0;
    repeat (2) @(negedge i_clk);
    #1;
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", obs); end
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    @(negedge i_clk);
  endtask

  task automatic test_single_normal();
    int lat;
    i_fmt_double = 1'b0; i_ready = 1'b1; i_valid = 1'b1;
    i_operands = {64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_C000_0000, 64'hFFFF_FFFF_3F80_0000};
    #1;
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin tick(); lat++; end
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL normal_latency: got %0d want 2", lat); end
    n_checks++;
    exp_o = (sb.size() > 0) ? sb.pop_front() : '0;
    if (obs !== exp_o) begin n_fail++; $display("FAIL normal_sb: got %h want %h", obs, exp_o); end
    n_checks++;
    if (o_exp[EW-1:0] !== 13'd127) begin
      n_fail++; $display("FAIL normal_exp: got %h want %h", o_exp[EW-1:0], 13'd127);
    end
    n_checks++;
    if (o_mant[MW-1:0] !== MANT_ONE) begin
      n_fail++; $display("FAIL normal_mant: got %h want %h", o_mant[MW-1:0], MANT_ONE);
    end
    n_checks++;
    if ({o_is_zero[0], o_is_subnormal[0], o_is_inf[0], o_is_nan[0], o_is_snan[0], o_box_fail[0]}
        !== 6'b0) begin
      n_fail++; $display("FAIL normal_flags: got %b%b%b%b%b%b want 000000", o_is_zero[0],
                         o_is_subnormal[0], o_is_inf[0], o_is_nan[0], o_is_snan[0], o_box_fail[0]);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL normal_drain: got %b want 0", o_valid); end
  endtask

  task automatic test_subnormal();
    i_ready = 1'b1; i_valid = 1'b1; i_fmt_double = 1'b0;
    i_operands = {64'hFFFF_FFFF_7F80_0000, 64'hFFFF_FFFF_8040_0000, 64'hFFFF_FFFF_0000_0001};
    #1; tick();
    i_fmt_double = 1'b1;
    i_operands = {64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};
    #1; tick();
    i_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (o_valid && i_ready) begin
        n_checks++;
        exp_o = (sb.size() > 0) ? sb.pop_front() : '0;
        if (obs !== exp_o) begin n_fail++; $display("FAIL sub_sb: got %h want %h", obs, exp_o); end
        n_checks++;
        if (!o_fmt_double && ({o_is_subnormal[0], o_exp[EW-1:0]} !== {1'b1, 13'h1FEA})) begin
          n_fail++; $display("FAIL sub_single: sub=%b exp=%h want sub=1 exp=1fea",
                             o_is_subnormal[0], o_exp[EW-1:0]);
        end else if (o_fmt_double && ({o_exp[EW +: EW], o_mant[MW +: MW]} !== {13'h1FCD, MANT_ONE})) begin
          n_fail++; $display("FAIL sub_double: exp=%h mant=%h want exp=1fcd mant=%h",
                             o_exp[EW +: EW], o_mant[MW +: MW], MANT_ONE);
        end
      end
      tick();
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sub_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_nan_box();
    i_ready = 1'b1; i_valid = 1'b1; i_fmt_double = 1'b0;
    i_operands = {64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_FFC0_0001, 64'hFFFF_FFFF_7FA0_0000};
    #1; tick();
    i_fmt_double = 1'b1;
    i_operands = {64'hFFF0_0000_0000_0000, 64'hFFF8_0000_0000_0000, 64'h7FF0_0000_0000_0001};
    #1; tick();
    i_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (o_valid && i_ready) begin
        n_checks++;
        exp_o = (sb.size() > 0) ? sb.pop_front() : '0;
        if (obs !== exp_o) begin n_fail++; $display("FAIL nan_sb: got %h want %h", obs, exp_o); end
        n_checks++;
        if (!o_fmt_double &&
            ({o_box_fail, o_is_nan[2], o_is_snan[2], o_sign[2]} !== 6'b100_1_0_0)) begin
          n_fail++; $display("FAIL nan_box: box=%b nan=%b snan=%b sign=%b want 100 1 0 0",
                             o_box_fail, o_is_nan[2], o_is_snan[2], o_sign[2]);
        end else if (o_fmt_double &&
            ({o_box_fail, o_is_nan[0], o_is_snan[0], o_mant[MW-1:0]} !==
             {3'b000, 1'b1, 1'b1, MANT_ONE | 53'd1})) begin
          n_fail++; $display("FAIL nan_snan: box=%b nan=%b snan=%b mant=%h want 000 1 1 %h",
                             o_box_fail, o_is_nan[0], o_is_snan[0], o_mant[MW-1:0],
                             MANT_ONE | 53'd1);
        end
      end
      tick();
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL nan_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [N*64-1:0] ops [4];
    logic fmts [4];
    int sent, got, stall_left;
    logic started, drop_seen;
    for (int i = 0; i < 4; i++) begin
      fmts[i] = i[0];
      ops[i]  = {rand_op(fmts[i]), rand_op(fmts[i]), rand_op(fmts[i])};
    end
    sent = 0; got = 0; stall_left = 0; started = 1'b0; drop_seen = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (o_valid && !started) begin started = 1'b1; stall_left = 3; snap = obs; end
      i_ready = (stall_left == 0);
      i_valid = (sent < 4);
      i_fmt_double = fmts[sent % 4];
      i_operands   = ops[sent % 4];
      #1;
      if (stall_left > 0) begin
        if (stall_left < 3) begin
          n_checks++;
          if ({o_valid, obs} !== {1'b1, snap}) begin
            n_fail++; $display("FAIL b2b_stable: got %b %h want 1 %h", o_valid, obs, snap);
          end
        end
        if (!o_ready && !drop_seen) begin
          drop_seen = 1'b1;
          n_checks++;
          if (sent != 2) begin n_fail++; $display("FAIL b2b_ready_drop: got %0d accepts want 2", sent); end
        end
        stall_left--;
      end
      if (o_valid && i_ready) begin
        got++;
        n_checks++;
        exp_o = (sb.size() > 0) ? sb.pop_front() : '0;
        if (obs !== exp_o) begin n_fail++; $display("FAIL b2b_sb: got %h want %h", obs, exp_o); end
      end
      if (i_valid && o_ready) sent++;
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    n_checks++;
    if ({got, sb.size(), 31'(drop_seen)} !== {32'd4, 32'd0, 31'd1}) begin
      n_fail++; $display("FAIL b2b_count: got=%0d pending=%0d drop=%b want 4 0 1",
                         got, sb.size(), drop_seen);
    end
  endtask

  task automatic test_flush();
    int lat, ghosts;
    i_ready = 1'b0; i_valid = 1'b1; i_fmt_double = 1'b1;
    i_operands = {64'h4000_0000_0000_0000, 64'h0000_0000_0000_0010, 64'h3FF0_0000_0000_0000};
    #1; tick();
    i_operands = {64'hC000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000};
    #1; tick();
    n_checks++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got %b want 1", o_valid); end
    i_flush = 1'b1; i_ready = 1'b1;
    i_operands = {64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000};
    #1; tick();
    sb.delete();
    i_flush = 1'b0; i_valid = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_clear: valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    i_valid = 1'b1; i_fmt_double = 1'b0;
    i_operands = {64'hFFFF_FFFF_4049_0FDB, 64'hFFFF_FFFF_0000_0100, 64'hFFFF_FFFF_BF80_0000};
    #1; tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin tick(); lat++; end
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL flush_latency: got %0d want 2", lat); end
    n_checks++;
    exp_o = (sb.size() > 0) ? sb.pop_front() : '0;
    if (obs !== exp_o) begin n_fail++; $display("FAIL flush_next: got %h want %h", obs, exp_o); end
    tick();
    ghosts = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_valid) ghosts++;
      tick();
    end
    n_checks++;
    if (ghosts != 0) begin n_fail++; $display("FAIL flush_ghost: got %0d outputs want 0", ghosts); end
  endtask

  task automatic test_reset_mid();
    int spurious;
    i_ready = 1'b1; i_valid = 1'b1; i_fmt_double = 1'b1;
    i_operands = {64'h4010_0000_0000_0000, 64'h8008_0000_0000_0000, 64'h3FF8_0000_0000_0000};
    #1; tick();
    i_operands = {64'h0010_0000_0000_0000, 64'h7FF4_0000_0000_0000, 64'hBFF0_0000_0000_0000};
    #1; tick();
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got %b want 1", o_valid); end
    #2;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, obs} !== '0) begin
      n_fail++; $display("FAIL rstmid_drop: valid=%b data=%h want 0 0", o_valid, obs);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", o_ready); end
    spurious = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (o_valid) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d outputs want 0", spurious); end
  endtask

  task automatic test_random();
    int sent;
    logic d;
    sent = 0;
    for (int c = 0; c < 600 && (sent < 30 || sb.size() > 0); c++) begin
      d = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0);
      i_valid = (sent < 30) && ($urandom_range(0, 3) != 0);
      i_fmt_double = d;
      i_operands = {rand_op(d), rand_op(d), rand_op(d)};
      #1;
      if (o_valid && i_ready) begin
        n_checks++;
        exp_o = (sb.size() > 0) ? sb.pop_front() : '0;
        if (obs !== exp_o) begin n_fail++; $display("FAIL rand_sb: got %h want %h", obs, exp_o); end
      end
      if (i_valid && o_ready) sent++;
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    n_checks++;
    if (sent != 30 || sb.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: sent=%0d pending=%0d want 30 0", sent, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_normal();
    test_subnormal();
    test_nan_box();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_operand_normalizer.md
Name: fp_operand_normalizer

Overview:
Pipelined multi-operand FP unpacker, classifier and subnormal normalizer for the FPU issue path.
- Accepts up to NUM_OPS packed operands in FLEN-wide registers, either single (NaN-boxed) or double format, selected per transaction.
- Emits sign, signed exponent, left-aligned normalized mantissa and class flags per operand, two cycles later.
- Valid/ready handshake with full backpressure and flush, so adder, multiplier, FMA, divider and sqrt share one front end.

Parameters:
FLEN, 64, register width; 64 only (single operands are NaN-boxed in the lower 32 bits).
NUM_OPS, 3, number of operand lanes (1..3).
EXP_W, 13, signed output exponent width (11 + 2 guard bits).
MANT_W, 53, output mantissa width (implicit bit included).

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_flush  in  1  kill all in-flight transactions
i_valid  in  1  input transaction valid
o_ready  out  1  block can accept input this cycle
i_fmt_double  in  1  1 = double format, 0 = single format
i_operands  in  NUM_OPS*FLEN  packed operands; lane k = bits [k*FLEN +: FLEN]
o_valid  out  1  output valid
i_ready  in  1  downstream accepts output
o_fmt_double  out  1  echoed format
o_sign  out  NUM_OPS  per-lane sign
o_exp  out  NUM_OPS*EXP_W  per-lane signed exponent in the format's native bias
o_mant  out  NUM_OPS*MANT_W  per-lane normalized mantissa, MSB = leading 1
o_is_zero, o_is_subnormal, o_is_inf, o_is_nan, o_is_snan  out  NUM_OPS each  per-lane class flags
o_box_fail  out  NUM_OPS  single-format lane whose upper 32 bits were not all ones

Behaviour:
- Reset (async, i_rst=1): both stage valids cleared. o_valid=0. All data outputs 0. o_ready=1 once reset is released.
- Stage 1 (registered at accept):
  - Field extract and NaN-box check.
  - Classify zero / subnormal / inf / NaN / sNaN.
  - Leading-zero count of the 24- or 53-bit mantissa.
- Stage 2 (registered):
  - Left-shift the mantissa by the lzc.
  - Compute exponent.
- Latency: exactly 2 cycles from accept (i_valid && o_ready) to o_valid, with no stalls. Throughput 1 per cycle.
- Handshake:
  - Stage 2 holds while o_valid && !i_ready.
  - Stage 1 advances when stage 2 is empty or draining.
  - o_ready = !s1_valid || s1_advance (combinational from i_ready; no skid buffer).
  - Outputs are stable while o_valid && !i_ready.
- Single lanes:
  - Mantissa is left-aligned: bits [52:29] hold 1.frac; bits [28:0] are 0.
  - Exponent uses bias 127.
- Double lanes use bias 1023.
- Box failure (single, upper 32 bits != all ones):
  - Lane treated as canonical qNaN 0x7FC00000: is_nan=1, is_snan=0, sign=0.
  - o_box_fail=1.
  - In double mode o_box_fail=0.
- Normal: exp = biased exponent (zero-extended); mant MSB=1.
- Subnormal: exp = 1 - lzc (can be negative); mant shifted so MSB=1; o_is_subnormal=1.
- Zero: exp=0, mant=0.
- Inf: exp = all-ones field value (255 / 2047), mant = 0.
- NaN: exp = all-ones field value; mant = {1'b1, frac} unshifted.
  - is_snan = NaN with frac MSB = 0.
- Exactly one of zero / subnormal / inf / nan is set for any non-normal lane; all are 0 for a normal lane.
- Flush:
  - Clears both stage valids at the next edge.
  - An input presented in the same cycle as i_flush is dropped, not accepted.
  - o_valid=0 the cycle after flush.
- Flush and i_ready in the same cycle: flush wins; no partial state survives.
- Reset mid-operation: all in-flight data discarded; no spurious o_valid after release.

Decomposition:
- Package fp_norm_pkg holds:
  - FLEN, EXP_W, MANT_W.
  - Per-format constants: EXP_BITS, FRAC_BITS, bias, canonical NaN 0x7FC00000.
  - Struct fp_norm_lane_t {sign, exp, mant, class flags, box_fail}.
- Sub-module fp_lzc: parametrised leading-zero counter (WIDTH, output $clog2(WIDTH+1)), instantiated per lane in stage 1.

Test Plan:
1. Single, lane0=0xFFFFFFFF_3F800000 (1.0) -> 2 cycles later exp=127, mant=1<<52, all flags 0, box_fail=0.
2. Single, lane0=0xFFFFFFFF_00000001 -> is_subnormal=1, exp=-22 (lzc=23), mant=1<<52; double, lane1=0x0000000000000001 -> exp=-51, mant=1<<52.
3. Single, lane2=0x00000000_3F800000 -> box_fail=1, is_nan=1, is_snan=0, sign=0; double 0x7FF0000000000001 -> is_nan=1, is_snan=1, mant=(1<<52)|1.
4. Back-to-back 4 transactions with i_ready held 0 for 3 cycles after the first output -> o_ready deasserts after 2 accepts; outputs stable; all 4 delivered in order, none lost or duplicated.
5. i_flush while both stages valid, with a new i_valid in the same cycle -> o_valid=0 next cycle; flushed input never appears; next accepted input appears 2 cycles later.
6. Assert i_rst asynchronously mid-stream -> o_valid and data drop to 0 immediately; o_ready=1 after release; no stale output.
